sign_extend: RTL and testbench

//  Widens a narrow immediate field to datapath width by replicating its MSB.

---
 rtl/sign_extend_pkg.sv | 17 +
 rtl/sign_extend_reg.sv | 35 +++
 rtl/sign_extend.sv | 61 ++++++
 tb/tb_sign_extend.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sign_extend_pkg.sv
// Shared constants, types and parameter checks for the sign_extend slice.
// Optional registered output is enabled with the SIGN_EXTEND_REG_OUT_EN macro.
package sign_extend_pkg;

  localparam int DATA_W = 16;  // datapath width
  localparam int IMM8_W = 8;   // common 8-bit immediate field
  localparam int IMM4_W = 4;   // short 4-bit immediate field

  typedef logic [IMM8_W-1:0] imm_t;
  typedef logic [DATA_W-1:0] word_t;

  // True when the width/shift combination can be built.
  function automatic bit params_legal(input int in_w, input int out_w, input int shift);
    return (in_w >= 2) && (in_w <= out_w) && (shift >= 0) && (shift <= 3);
  endfunction

endpackage

// File: rtl/sign_extend_reg.sv
// OUT_WIDTH-wide register with asynchronous active-high clear.
// Used by sign_extend only when SIGN_EXTEND_REG_OUT_EN is defined.
module sign_extend_reg
  import sign_extend_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  // Next-state is simply the incoming value.
  // NOTE: every always_comb output is assigned on all paths, so no latch is inferred.
  always_comb begin
    data_d = d;
  end

  // Capture on each rising edge; clear immediately when reset rises.
  // NOTE: non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/sign_extend.sv
// Widens an immediate field to datapath width (sign or zero fill), then
// applies a fixed left shift. Combinational result is always present.
// Define SIGN_EXTEND_REG_OUT_EN to register out_bit_string_q (1-cycle
// latency, async clear); otherwise out_bit_string_q mirrors the
// combinational result and clk/reset are unused.
module sign_extend
  import sign_extend_pkg::*;
#(
  parameter int IN_WIDTH  = IMM8_W,
  parameter int OUT_WIDTH = DATA_W,
  parameter int ZERO_EXT  = 0,
  parameter int SHIFT     = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_WIDTH-1:0]  in_bit_string,
  output logic [OUT_WIDTH-1:0] out_bit_string,
  output logic [OUT_WIDTH-1:0] out_bit_string_q,
  output logic                 is_negative
);

  logic                 fill;
  logic [OUT_WIDTH-1:0] ext;

  // Fill bit: the source MSB in sign mode, zero in zero-extend mode.
  assign fill = (ZERO_EXT != 0) ? 1'b0 : in_bit_string[IN_WIDTH-1];

  // Extension: the equal-width case is a plain pass-through because a
  // zero-count replication is not legal.
  if (!params_legal(IN_WIDTH, OUT_WIDTH, SHIFT)) begin : g_illegal
    $error("sign_extend: illegal parameters IN_WIDTH=%0d OUT_WIDTH=%0d SHIFT=%0d",
           IN_WIDTH, OUT_WIDTH, SHIFT);
    assign ext = '0;
  end else if (IN_WIDTH == OUT_WIDTH) begin : g_pass
    assign ext = in_bit_string;
  end else begin : g_extend
    assign ext = {{(OUT_WIDTH-IN_WIDTH){fill}}, in_bit_string};
  end

  // Shift after extension; MSBs fall off, LSBs fill with zero.
  assign out_bit_string = ext << SHIFT;
  assign is_negative    = fill;

`ifdef SIGN_EXTEND_REG_OUT_EN
  sign_extend_reg #(
    .WIDTH (OUT_WIDTH)
  ) u_reg (
    .clk   (clk),
    .reset (reset),
    .d     (out_bit_string),
    .q     (out_bit_string_q)
  );
`else
  assign out_bit_string_q = out_bit_string;

  // clk and reset are part of the fixed interface but have no load here.
  logic unused_clk_reset;
  assign unused_clk_reset = clk ^ reset;
`endif

endmodule

// File: tb/tb_sign_extend.sv
// Self-checking bench for sign_extend: five parameterisations share one
// stimulus word; a scoreboard queue carries expected results from drive
// to compare. Registered-path expectations follow SIGN_EXTEND_REG_OUT_EN.
module tb_sign_extend;

`ifdef SIGN_EXTEND_REG_OUT_EN
  localparam bit REG_MODE = 1'b1;
`else
  localparam bit REG_MODE = 1'b0;
`endif

  localparam int N_DUT = 5;

  typedef struct packed {
    logic [N_DUT-1:0][15:0] out;
    logic [N_DUT-1:0]       neg;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        clk_run = 1'b0;
  logic [15:0] stim;

  logic [15:0] obs_out [N_DUT];
  logic [15:0] obs_q   [N_DUT];
  logic        obs_neg [N_DUT];

  exp_t        comb_sb[$];
  logic [15:0] q_sb[$];

  int n_checks = 0;
  int n_errors = 0;

  // Instance 0: defaults (8 -> 16, sign, no shift).
  sign_extend u_dut0 (
    .clk (clk), .reset (reset), .in_bit_string (stim[7:0]),
    .out_bit_string (obs_out[0]), .out_bit_string_q (obs_q[0]), .is_negative (obs_neg[0])
  );
  // Instance 1: zero extend.
  sign_extend #(.IN_WIDTH(8), .OUT_WIDTH(16), .ZERO_EXT(1), .SHIFT(0)) u_dut1 (
    .clk (clk), .reset (reset), .in_bit_string (stim[7:0]),
    .out_bit_string (obs_out[1]), .out_bit_string_q (obs_q[1]), .is_negative (obs_neg[1])
  );
  // Instance 2: sign extend then shift by one.
  sign_extend #(.IN_WIDTH(8), .OUT_WIDTH(16), .ZERO_EXT(0), .SHIFT(1)) u_dut2 (
    .clk (clk), .reset (reset), .in_bit_string (stim[7:0]),
    .out_bit_string (obs_out[2]), .out_bit_string_q (obs_q[2]), .is_negative (obs_neg[2])
  );
  // Instance 3: equal widths (pass-through) with maximum shift.
  sign_extend #(.IN_WIDTH(16), .OUT_WIDTH(16), .ZERO_EXT(0), .SHIFT(3)) u_dut3 (
    .clk (clk), .reset (reset), .in_bit_string (stim),
    .out_bit_string (obs_out[3]), .out_bit_string_q (obs_q[3]), .is_negative (obs_neg[3])
  );
  // Instance 4: 4-bit field, shift by two.
  sign_extend #(.IN_WIDTH(4), .OUT_WIDTH(16), .ZERO_EXT(0), .SHIFT(2)) u_dut4 (
    .clk (clk), .reset (reset), .in_bit_string (stim[3:0]),
    .out_bit_string (obs_out[4]), .out_bit_string_q (obs_q[4]), .is_negative (obs_neg[4])
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  // Arithmetic reference: interpret the low w bits as signed/unsigned,
  // multiply by 2**sh, keep 16 bits.
  function automatic logic [15:0] model(input logic [15:0] v, input int w,
                                        input bit zx, input int sh);
    longint val;
    val = 0;
    for (int i = 0; i < w; i++) if (v[i]) val += (longint'(1) << i);
    if (!zx && v[w-1]) val -= (longint'(1) << w);
    val = val * (longint'(1) << sh);
    return val[15:0];
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a stimulus word; exp0 is the expected default-instance result.
  task automatic drive(input logic [15:0] v, input logic [15:0] exp0);
    exp_t e;
    stim     = v;
    e.out[0] = exp0;             e.neg[0] = v[7];
    e.out[1] = model(v, 8, 1, 0);  e.neg[1] = 1'b0;
    e.out[2] = model(v, 8, 0, 1);  e.neg[2] = v[7];
    e.out[3] = model(v, 16, 0, 3); e.neg[3] = v[15];
    e.out[4] = model(v, 4, 0, 2);  e.neg[4] = v[3];
    comb_sb.push_back(e);
    q_sb.push_back(exp0);
  endtask

  // Pop the oldest combinational expectation and compare every instance.
  task automatic check_comb(input string tag);
    exp_t e;
    if (comb_sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = comb_sb.pop_front();
      for (int i = 0; i < N_DUT; i++) begin
        check($sformatf("%s_out%0d", tag, i), obs_out[i], e.out[i]);
        check($sformatf("%s_neg%0d", tag, i), {15'd0, obs_neg[i]}, {15'd0, e.neg[i]});
      end
    end
  endtask

  // Pop the oldest registered expectation and compare instance 0's q.
  task automatic check_q(input string tag);
    logic [15:0] e;
    if (q_sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = q_sb.pop_front();
      check(tag, obs_q[0], e);
    end
  endtask

  initial begin
    logic [15:0] v;

    // Combinational phase: clk and reset left undriven, no clock edges.
    stim = '0;
    drive(16'h00F0, 16'hFFF0); #10 check_comb("neg_f0");
    drive(16'h000F, 16'h000F); #10 check_comb("pos_0f");
    drive(16'h0080, 16'hFF80); #10 check_comb("min_80");
    drive(16'h007F, 16'h007F); #10 check_comb("max_7f");
    drive(16'h0000, 16'h0000); #10 check_comb("zeros");
    drive(16'h00FF, 16'hFFFF); #10 check_comb("ones");
    drive(16'h8001, 16'h0001); #10 check_comb("wide_8001");
    drive(16'h7FF8, 16'hFFF8); #10 check_comb("wide_7ff8");
    for (int k = 0; k < 4; k++) begin
      v = 16'($urandom);
      drive(v, model(v, 8, 0, 0)); #10 check_comb("rand_comb");
    end
    q_sb.delete();

    // Registered phase.
    clk     = 1'b0;
    reset   = 1'b1;
    clk_run = 1'b1;

    @(negedge clk);
    drive(16'h00F0, 16'hFFF0); #1 check_comb("comb_in_reset");
    void'(q_sb.pop_front());
    check("q_in_reset", obs_q[0], REG_MODE ? 16'h0000 : 16'hFFF0);
    @(posedge clk); #1
    check("q_held_reset_edge", obs_q[0], REG_MODE ? 16'h0000 : 16'hFFF0);

    @(negedge clk);
    reset = 1'b0;
    #1 check("q_before_edge", obs_q[0], REG_MODE ? 16'h0000 : 16'hFFF0);
    @(posedge clk); #1 check("q_after_edge", obs_q[0], 16'hFFF0);

    @(negedge clk);
    drive(16'h007F, 16'h007F); #1 check_comb("comb_7f");
    check("q_hold_prev", obs_q[0], REG_MODE ? 16'hFFF0 : 16'h007F);
    @(posedge clk); #1 check_q("q_load_7f");

    @(negedge clk);
    drive(16'h00F0, 16'hFFF0); #1 check_comb("comb_f0_again");
    @(posedge clk); #1 check_q("q_load_f0");

    // Reset pulse between edges.
    #2 reset = 1'b1;
    #1 check("q_async_clear", obs_q[0], REG_MODE ? 16'h0000 : 16'hFFF0);
    check("out_during_reset", obs_out[0], 16'hFFF0);
    check("neg_during_reset", {15'd0, obs_neg[0]}, 16'h0001);
    reset = 1'b0;
    #1 check("q_after_release", obs_q[0], REG_MODE ? 16'h0000 : 16'hFFF0);
    @(posedge clk); #1 check("q_reload", obs_q[0], 16'hFFF0);

    // Streamed random values through the registered path.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      v = 16'($urandom);
      drive(v, model(v, 8, 0, 0)); #1 check_comb("rand_seq");
      @(posedge clk); #1 check_q("rand_q");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
